// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter and anything that drives or
// checks it, so the mode encoding has exactly one definition.
package counter_pkg;

    // Width used when an instance does not override WIDTH.
    localparam int DEFAULT_WIDTH = 4;

    // Legal bounds for the WIDTH parameter.
    localparam int MIN_WIDTH = 1;
    localparam int MAX_WIDTH = 32;

    // Direction encoding on the mode input.
    localparam logic MODE_DOWN = 1'b0;
    localparam logic MODE_UP   = 1'b1;

endpackage : counter_pkg

// File: rtl/updown_counter.sv
// Free-running WIDTH-bit binary up/down counter. The mode input picks the
// direction on every clock, the value wraps modulo 2^WIDTH both ways, and
// a synchronous active-high reset forces zero with priority over the mode.
module updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             m,
    input  logic             rst,
    output logic [WIDTH-1:0] count
);

    // Reject widths outside the supported range while elaborating.
    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_badWidth
        $error("updown_counter: WIDTH must be in 1..32");
    end

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_next;

    // Step is +1 or all-ones (i.e. -1 in two's complement). Everything goes
    // through one adder, so the carry-out simply falls off the top and the
    // wrap in both directions comes for free. An unknown mode makes the step,
    // and therefore the count, unknown in simulation.
    always_comb begin
        w_step = (m == MODE_UP) ? WIDTH'(1) : '1;
        w_next = r_count + w_step;
    end

    // State register: reset wins over counting on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign count = r_count;

endmodule : updown_counter

// File: tb/tb_updown_counter.sv
// Scoreboard bench for updown_counter: stimulus pushes the value a
// modular-arithmetic reference predicts, a monitor pops and compares after
// every rising edge.
module tb_updown_counter;
    import counter_pkg::*;

    localparam int W   = DEFAULT_WIDTH;
    localparam int MOD = 1 << W;

    typedef struct {
        logic [W-1:0] value;
        string        tag;
    } expEntry_t;

    logic         clk = 1'b0;
    logic         m   = MODE_DOWN;
    logic         rst = 1'b0;
    logic [W-1:0] count;

    expEntry_t expQ[$];
    int        modelValue = 0;
    int        checksTotal = 0;
    int        checksPassed = 0;

    updown_counter #(.WIDTH(W)) dut (
        .clk   (clk),
        .m     (m),
        .rst   (rst),
        .count (count)
    );

    // 4 ns clock period.
    always #2 clk = ~clk;

    // Compare one observed value against its expectation.
    task automatic checkOutput(input string tag, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        checksTotal++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: count=%0d expected=%0d", tag, actual, expected);
        end else begin
            checksPassed++;
        end
    endtask

    // Drive one cycle of inputs at the falling edge, advance the reference
    // model by the counter's rules and queue the value due after the next
    // rising edge.
    task automatic applyStimulus(input logic rstVal, input logic mVal, input string tag);
        expEntry_t e;
        @(negedge clk);
        rst = rstVal;
        m   = mVal;
        if (rstVal)
            modelValue = 0;
        else if (mVal == MODE_UP)
            modelValue = (modelValue + 1) % MOD;
        else
            modelValue = (modelValue + MOD - 1) % MOD;
        e.value = W'(modelValue);
        e.tag   = tag;
        expQ.push_back(e);
    endtask

    // Monitor: the counter presents a new value after every rising edge.
    initial begin
        expEntry_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e.tag, count, e.value);
            end
        end
    end

    initial begin
        int lenDown;
        int lenUp;
        int lenRst;

        // Reset held for two edges, then count down from zero.
        applyStimulus(1'b1, MODE_DOWN, "reset_hold");
        applyStimulus(1'b1, MODE_DOWN, "reset_hold");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, MODE_DOWN, "reset_release_down");

        // Up count through the wrap.
        applyStimulus(1'b1, MODE_UP, "reset_before_up");
        for (int i = 0; i < 17; i++) applyStimulus(1'b0, MODE_UP, "up_wrap");

        // Down count through the wrap.
        applyStimulus(1'b1, MODE_UP, "reset_before_down");
        for (int i = 0; i < 17; i++) applyStimulus(1'b0, MODE_DOWN, "down_wrap");

        // Direction reversal with no hold cycle.
        applyStimulus(1'b1, MODE_DOWN, "reset_before_reverse");
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, MODE_UP, "reverse_up");
        applyStimulus(1'b0, MODE_DOWN, "reverse_down");
        applyStimulus(1'b0, MODE_DOWN, "reverse_down");
        applyStimulus(1'b0, MODE_UP, "reverse_up_again");

        // Mid-count reset with reset overriding the mode.
        applyStimulus(1'b1, MODE_UP, "reset_before_mid");
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, MODE_UP, "mid_count_up");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, MODE_DOWN, "mid_reset_hold");
        applyStimulus(1'b0, MODE_UP, "mid_reset_release_up");

        // Long run: 200 ns down, 200 ns up, 100 ns reset, then down again.
        lenDown = 200 / 4;
        lenUp   = 200 / 4;
        lenRst  = 100 / 4;
        for (int i = 0; i < lenDown; i++) applyStimulus(1'b0, MODE_DOWN, "long_down");
        for (int i = 0; i < lenUp; i++)   applyStimulus(1'b0, MODE_UP, "long_up");
        for (int i = 0; i < lenRst; i++)  applyStimulus(1'b1, MODE_UP, "long_reset");
        for (int i = 0; i < 20; i++)      applyStimulus(1'b0, MODE_DOWN, "long_down_after_reset");

        // Random mode with occasional resets.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 15) == 0), logic'($urandom_range(0, 1)), "random");
        end

        // Let the monitor drain the queue, bounded by a few cycles.
        for (int i = 0; i < 8 && expQ.size() > 0; i++) @(negedge clk);
        checksTotal++;
        if (expQ.size() != 0)
            $display("[TB] FAIL scoreboard_drain: pending=%0d expected=0", expQ.size());
        else
            checksPassed++;

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule : tb_updown_counter

// File: doc/updown_counter.md
Name: updown_counter

Overview:
Free-running, parameterised binary up/down counter. Default width is 4 bits.
- Direction is selected every clock by a single mode input.
- Used as a generic count/sequence source and as a lab reference block for counter verification.
- Counter wraps modulo 2^WIDTH in both directions.
- No terminal-count gating.

Parameters:
WIDTH, 4, bit width of count; legal range 1..32.

Ports:
clk  input  1  rising-edge clock; the only clock domain.
rst  input  1  reset; synchronous, active-high.
m  input  1  mode: 1 = count up, 0 = count down.
count  output  WIDTH  current counter value, driven directly from a register.
Positional port order for instantiation is clk, m, rst, count. Integrators must keep this order.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates happen on the rising edge of clk only.
- Reset:
  - On a rising edge with rst=1, count <= 0, regardless of m.
  - While rst stays high, count holds 0 every cycle.
  - There is no asynchronous path; asserting rst between edges has no effect until the next edge.
  - Before the first edge sampling rst=1, count is undefined. Benches must apply reset before checking values.
- Counting, on each rising edge with rst=0:
  - m=1: count <= count + 1 (mod 2^WIDTH).
  - m=0: count <= count - 1 (mod 2^WIDTH).
- Latency:
  - A change on m takes effect at the first rising edge that samples the new value.
  - count changes exactly one cycle per step, with no pipeline delay.
- Wrap-around:
  - Up from 2^WIDTH-1 (15 for WIDTH=4) gives 0.
  - Down from 0 gives 2^WIDTH-1 (15).
  - No overflow or underflow flag.
- Reset priority: rst=1 overrides m on the same edge. The first edge with rst=0 counts from 0 in the direction given by m (m=0 gives 15, m=1 gives 1).
- Mid-count reset: any value returns to 0 on the next edge with rst=1.
- Direction reversal: switching m between edges reverses on the next edge, with no extra hold cycle. Example: 7 up then m=0 gives 6.
- X handling: if m is unknown while rst=0, count becomes unknown in simulation. There are no X-suppression requirements. The RTL must not add latches or combinational loops.
- Arithmetic: a single WIDTH-bit adder/subtractor; carry-out is discarded.
- count is a pure register output, with no combinational path from any input to count.

Decomposition:
- Shared package (counter_pkg):
  - default width constant (4);
  - mode encodings MODE_DOWN = 1'b0 and MODE_UP = 1'b1, used by RTL and bench.
- No sub-module. A single always block with next-state logic inline is sufficient.
- Optional elaboration-time assertion that WIDTH >= 1.

Test Plan:
1. Reset: rst=1 for 2 edges with m=0 -> count=0 on both edges. Release rst with m=0 -> 15, 14, 13 on successive edges.
2. Up count and wrap: reset, then m=1 for 17 edges -> 1, 2, …, 15, 0, 1.
3. Down count and wrap: reset, then m=0 for 17 edges -> 15, 14, …, 1, 0, 15.
4. Direction reversal: from reset, m=1 for 7 edges (count=7), then m=0 -> 6, 5. Then m=1 -> 6.
5. Mid-operation reset with priority: count=9 counting up; set rst=1 with m=0 -> 0 on the next edge and held for 3 edges. Release with m=1 -> 1.
6. Long run: clk period 4 ns, m=0 for 200 ns, m=1 for 200 ns, then rst=1 for 100 ns, then rst=0. Check each edge against a reference model: mod-16 decrement, then mod-16 increment, then 0 during reset, then decrement from 0 (first value 15).
